// File: rtl/fft64_pkg.sv
// fft64_pkg: shared widths, FSM encoding and lane slicing for the FFT64 input unit.
package fft64_pkg;
  localparam int DW = 10;
  localparam int LANES = 8;
  localparam int N = LANES * LANES;
  typedef enum logic [1:0] {FILL, WAIT, EMIT} state_t;
  function automatic int lane_lo(input int i);
    return DW * i;
  endfunction
endpackage

// File: rtl/fft64_input_unit_if.sv
// fft64_input_unit_if: sample input stream and beat output bus of the FFT64 input unit.
interface fft64_input_unit_if;
  import fft64_pkg::*;
  logic din_valid;
  logic [DW-1:0] dinre;
  logic [DW-1:0] dinim;
  logic din_ready;
  logic core_ready;
  logic [LANES*DW-1:0] doutre;
  logic [LANES*DW-1:0] doutim;
  logic [2:0] doutcounter;
  logic dout_valid;
  logic dout_start;
  logic drop_err;
  modport slave (
    input din_valid, dinre, dinim, core_ready,
    output din_ready, doutre, doutim, doutcounter, dout_valid, dout_start, drop_err
  );
  modport master (
    output din_valid, dinre, dinim, core_ready,
    input din_ready, doutre, doutim, doutcounter, dout_valid, dout_start, drop_err
  );
endinterface

// File: rtl/fft64_input_unit_shift_register8_ip.sv
// shift_register8_ip: 8-entry re/im column with one write row and a registered read row.
module shift_register8_ip
  import fft64_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic we,
  input  logic [2:0] wrow,
  input  logic [DW-1:0] wre,
  input  logic [DW-1:0] wim,
  input  logic rd_en,
  input  logic [2:0] rrow,
  output logic [DW-1:0] rd_re,
  output logic [DW-1:0] rd_im
);
  logic [DW-1:0] mem_re [LANES];
  logic [DW-1:0] mem_im [LANES];
  always_ff @(posedge clk) begin
    if (we) begin
      mem_re[wrow] <= wre;
      mem_im[wrow] <= wim;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_re <= '0;
      rd_im <= '0;
    end else if (rd_en) begin
      rd_re <= mem_re[rrow];
      rd_im <= mem_im[rrow];
    end
  end
endmodule

// File: rtl/fft64_input_unit.sv
// fft64_input_unit: buffers a 64-sample frame and emits it as 8 radix-8 grouped beats.
module fft64_input_unit
  import fft64_pkg::*;
(
  input logic clk,
  input logic rst_n,
  fft64_input_unit_if.slave bus
);
  state_t state;
  logic [5:0] sample_cnt;
  logic [2:0] beat_cnt;
  logic accept;
  logic emit;
  logic [LANES-1:0][DW-1:0] col_re;
  logic [LANES-1:0][DW-1:0] col_im;
  assign bus.din_ready = (state == FILL);
  assign accept = bus.din_valid & bus.din_ready;
  assign emit = (state == EMIT);
  assign bus.doutre = col_re;
  assign bus.doutim = col_im;
  // Column i holds samples 8i..8i+7, so beat r is row r read across all columns at once.
  for (genvar i = 0; i < LANES; i++) begin : g_col
    shift_register8_ip u_col (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (accept && sample_cnt[5:3] == 3'(i)),
      .wrow  (sample_cnt[2:0]),
      .wre   (bus.dinre),
      .wim   (bus.dinim),
      .rd_en (emit),
      .rrow  (beat_cnt),
      .rd_re (col_re[i]),
      .rd_im (col_im[i])
    );
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
      sample_cnt <= '0;
      beat_cnt <= '0;
      bus.doutcounter <= '0;
      bus.dout_valid <= 1'b0;
      bus.dout_start <= 1'b0;
      bus.drop_err <= 1'b0;
    end else begin
      bus.drop_err <= bus.din_valid & ~bus.din_ready;
      bus.dout_valid <= emit;
      bus.dout_start <= emit && beat_cnt == 3'd0;
      if (emit) bus.doutcounter <= beat_cnt;
      case (state)
        FILL: if (accept) begin
          sample_cnt <= sample_cnt + 6'd1;
          if (&sample_cnt) state <= WAIT;
        end
        WAIT: if (bus.core_ready) state <= EMIT;
        EMIT: begin
          beat_cnt <= beat_cnt + 3'd1;
          if (&beat_cnt) state <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule
